// File: rtl/clock_ctrl_pkg.sv
// Shared types, constants and BCD stepping helpers for the clock time-set controller.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_HH = 2'd1,
        SET_MM = 2'd2,
        COMMIT = 2'd3
    } state_e;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HH   = 2'd1;
    localparam logic [1:0] FIELD_MM   = 2'd2;

    localparam logic [7:0] HH_RESET = 8'h12;
    localparam logic [7:0] MM_RESET = 8'h00;
    localparam logic [7:0] SS_LOAD  = 8'h00;

    // Returns {pm, hh}; AM/PM flips on 11 -> 12, not on 12 -> 01.
    function automatic logic [8:0] hh_step(input logic pm, input logic [7:0] hh);
        logic [8:0] r;
        case (hh)
            8'h01, 8'h02, 8'h03, 8'h04,
            8'h05, 8'h06, 8'h07, 8'h08: r = {pm, hh + 8'h01};
            8'h09:                      r = {pm, 8'h10};
            8'h10:                      r = {pm, 8'h11};
            8'h11:                      r = {~pm, 8'h12};
            default:                    r = {pm, 8'h01};
        endcase
        return r;
    endfunction

    function automatic logic [7:0] mm_step(input logic [7:0] mm);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = mm[7:4];
        lo = mm[3:0];
        if (lo >= 4'd9) begin
            lo = 4'd0;
            hi = (hi >= 4'd5) ? 4'd0 : hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button, current-time and load bus between the set controller and its neighbours.
interface clock_set_ctrl_if;
    logic       mode_btn;
    logic       inc_btn;
    logic       cur_pm;
    logic [7:0] cur_hh;
    logic [7:0] cur_mm;
    logic       ena;
    logic       load;
    logic       ld_pm;
    logic [7:0] ld_hh;
    logic [7:0] ld_mm;
    logic [7:0] ld_ss;
    logic [1:0] edit_field;

    modport master (
        output mode_btn, inc_btn, cur_pm, cur_hh, cur_mm,
        input  ena, load, ld_pm, ld_hh, ld_mm, ld_ss, edit_field
    );

    modport slave (
        input  mode_btn, inc_btn, cur_pm, cur_hh, cur_mm,
        output ena, load, ld_pm, ld_hh, ld_mm, ld_ss, edit_field
    );
endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a registered one-cycle tick every TICK_DIV cycles while run is high.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);
    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q, count_d;
    logic          tick_q, tick_d;

    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            if (count_q == LAST) begin
                count_d = '0;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller in front of the 12-hour BCD clock: seconds enable, two-button
// edit of an hh/mm/pm shadow, and a one-cycle load strobe on commit.
//
// state   | meaning
// RUN     | clock counting, ena pulses every TICK_DIV cycles
// SET_HH  | counter frozen, inc steps hours (and AM/PM)
// SET_MM  | counter frozen, inc steps minutes
// COMMIT  | one cycle, load strobe to the clock counter
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100,
    parameter int unsigned TIMEOUT  = 1000
) (
    input logic             clk,
    input logic             reset,
    clock_set_ctrl_if.slave bus
);
    localparam logic [1:0] ST_RUN    = RUN;
    localparam logic [1:0] ST_SET_HH = SET_HH;
    localparam logic [1:0] ST_SET_MM = SET_MM;
    localparam logic [1:0] ST_COMMIT = COMMIT;

    localparam int unsigned TO_W = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic            pm_q, pm_d;
    logic [7:0]      hh_q, hh_d;
    logic [7:0]      mm_q, mm_d;
    logic            load_q, load_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [8:0]      hh_nxt;
    logic            pre_run;
    logic            tick;

    always_comb begin
        state_d = state_q;
        pm_d    = pm_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        to_d    = '0;
        hh_nxt  = hh_step(pm_q, hh_q);
        case (state_q)
            ST_RUN: begin
                if (bus.mode_btn) begin
                    state_d = ST_SET_HH;
                    pm_d    = bus.cur_pm;
                    hh_d    = bus.cur_hh;
                    mm_d    = bus.cur_mm;
                end
            end
            ST_SET_HH: begin
                if (bus.mode_btn) begin
                    state_d = ST_SET_MM;
                end else if (bus.inc_btn) begin
                    {pm_d, hh_d} = hh_nxt;
                end else if (to_q == TO_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            ST_SET_MM: begin
                if (bus.mode_btn) begin
                    state_d = ST_COMMIT;
                end else if (bus.inc_btn) begin
                    mm_d = mm_step(mm_q);
                end else if (to_q == TO_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            ST_COMMIT: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    assign load_d = (state_d == ST_COMMIT);

    // The prescaler already counts during the load cycle so the first tick lands TICK_DIV cycles after it.
    assign pre_run = ((state_q == ST_RUN) && !bus.mode_btn) || (state_q == ST_COMMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            pm_q    <= 1'b0;
            hh_q    <= HH_RESET;
            mm_q    <= MM_RESET;
            load_q  <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            pm_q    <= pm_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            load_q  <= load_d;
            to_q    <= to_d;
        end
    end

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .run  (pre_run),
        .clear(~pre_run),
        .tick (tick)
    );

    always_comb begin
        case (state_q)
            ST_SET_HH: bus.edit_field = FIELD_HH;
            ST_SET_MM: bus.edit_field = FIELD_MM;
            default:   bus.edit_field = FIELD_NONE;
        endcase
    end

    assign bus.ena   = tick;
    assign bus.load  = load_q;
    assign bus.ld_pm = pm_q;
    assign bus.ld_hh = hh_q;
    assign bus.ld_mm = mm_q;
    assign bus.ld_ss = SS_LOAD;
endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Controller placed in front of the 12-hour BCD clock counter (pm/hh/mm/ss).
- Generates the once-per-second count enable from the system clock.
- Runs a two-button time-set state machine: mode and increment.
- While a set is in progress, freezes the counter and edits a hours/minutes/AM-PM shadow.
- On commit, issues a one-cycle load with seconds cleared to 00.

Parameters:
TICK_DIV, 100, system clk cycles per ena pulse; legal range 2..2^24.
TIMEOUT, 1000, clk cycles without any button pulse in a SET state before aborting; legal range at least 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
mode_btn  input  1  single-cycle, debounced pulse; advances the set FSM.
inc_btn  input  1  single-cycle, debounced pulse; increments the field being edited.
cur_pm  input  1  current pm value from the clock counter.
cur_hh  input  8  current hours from the clock counter, BCD 01..12.
cur_mm  input  8  current minutes from the clock counter, BCD 00..59.
ena  output  1  registered count enable to the clock counter.
load  output  1  registered one-cycle load strobe to the clock counter.
ld_pm  output  1  pm value to load.
ld_hh  output  8  hours value to load, BCD.
ld_mm  output  8  minutes value to load, BCD.
ld_ss  output  8  seconds value to load; constant 8'h00.
edit_field  output  2  field being edited: 0 = none, 1 = hours, 2 = minutes.

Behaviour:
- Reset (async assert, sync release):
  - state=RUN, prescaler=0, timeout counter=0.
  - ena=0, load=0, edit_field=0.
  - ld_pm=0, ld_hh=8'h12, ld_mm=8'h00, ld_ss=8'h00.
- States: RUN, SET_HH, SET_MM, COMMIT.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - ena=1 for exactly the one cycle after the edge at which prescaler==TICK_DIV-1.
  - First ena is seen on the TICK_DIV-th rising edge after reset release; then one pulse every TICK_DIV cycles.
  - inc_btn is ignored.
  - mode_btn: next state SET_HH; capture cur_pm/cur_hh/cur_mm into ld_pm/ld_hh/ld_mm on the same edge; prescaler cleared to 0; ena=0 from that edge, even if a tick was due.
- SET_HH (edit_field=1):
  - ena held 0; prescaler held 0.
  - inc_btn steps ld_hh: 01..08 → +1, 09 → 10, 10 → 11, 11 → 12 with ld_pm toggled, 12 → 01 with ld_pm unchanged.
  - mode_btn: next state SET_MM.
- SET_MM (edit_field=2):
  - inc_btn steps ld_mm in BCD: low digit 9 → 0 with the high digit +1; 59 → 00.
  - No carry from minutes into hours.
  - mode_btn: next state COMMIT.
- COMMIT (edit_field=0, one cycle):
  - load=1 for exactly this cycle; ld_* stable; ld_ss=00; ena=0.
  - Next state RUN with prescaler=0, so the next ena arrives TICK_DIV cycles after the load cycle.
- Timeout:
  - The counter increments every cycle in SET_HH/SET_MM and clears on any mode_btn or inc_btn pulse.
  - When it reaches TIMEOUT-1: next state RUN, no load, edits discarded (ld_* keep their values but load never fires), prescaler restarts from 0.
- Simultaneous mode_btn and inc_btn: mode wins; the inc is dropped, not deferred.
- Shadow register inputs: cur_* inputs are sampled only on the RUN→SET_HH edge; any later change is ignored.
- Reset mid-edit or during COMMIT: immediately RUN, load deasserts asynchronously, nothing is loaded.
- Invariant: ena and load are never high in the same cycle.
- Illegal state encodings recover to RUN.

Decomposition:
- Package clock_ctrl_pkg:
  - state enum {RUN, SET_HH, SET_MM, COMMIT}.
  - edit_field constants FIELD_NONE=0, FIELD_HH=1, FIELD_MM=2.
  - Constants HH_RESET=8'h12, MM_RESET=8'h00.
- One sub-module: tick_prescaler.
  - Parameter TICK_DIV; inputs clk, reset, run, clear; output tick.
  - Width is $clog2(TICK_DIV).
- BCD stepping for hours and minutes is done inline as combinational functions in the package.

Test Plan:
All runs use TICK_DIV=4 and TIMEOUT=16.
1. Release reset, idle for 13 cycles: ena pulses on cycles 4, 8, 12; load never asserts; ld_hh=12, ld_pm=0.
2. cur=11:58 AM; apply mode, inc, mode, inc×2, mode: one load cycle with ld_hh=12, ld_pm=1, ld_mm=00, ld_ss=00; next ena exactly 4 cycles after load.
3. Hour wrap: cur_hh=12, cur_pm=1; enter SET_HH, inc: ld_hh=01, ld_pm=1; inc×10 more: ld_hh=11, ld_pm=1; one more inc: ld_hh=12, ld_pm=0.
4. Apply mode_btn and inc_btn in the same cycle in SET_HH: move to SET_MM with ld_hh unchanged.
5. In SET_MM, no buttons for 16 cycles: return to RUN with no load pulse; ena resumes 4 cycles later.
6. Assert reset mid-SET_MM, asynchronously between edges: outputs return to reset values immediately with no load; confirm ena and load are never high together across the whole run.
